// File: rtl/fir_tap_sequencer.sv
// Schedules the shared FIR MAC datapath and single-port coefficient RAM per PCM sample,
// and slots CPU coefficient writes into idle gaps of that schedule.
module fir_tap_sequencer #(
    parameter int NUM_FILTERS = 4,
    parameter int COEF_AW     = 10,
    parameter int SAMP_AW     = 8,
    localparam int FW         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               audio_en,
    input  logic               coef_rst,
    input  logic [7:0]         taps_per_filter,
    input  logic               coef_wr_en,
    input  logic [15:0]        coef_wr_data,
    input  logic               l_data_valid,
    input  logic               r_data_valid,
    output logic [COEF_AW-1:0] coef_addr,
    output logic               coef_we,
    output logic [15:0]        coef_wdata,
    output logic               samp_we,
    output logic               samp_wr_ch,
    output logic [SAMP_AW-1:0] samp_wr_addr,
    output logic               samp_rd_ch,
    output logic [SAMP_AW-1:0] samp_rd_addr,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               mac_last,
    output logic [FW-1:0]      mac_filter,
    output logic               out_valid_l,
    output logic               out_valid_r,
    output logic               busy,
    output logic               wr_addr_zero,
    output logic               overrun
);

    // state | meaning
    // IDLE  | arbitrate: pending coef write first, then L job, then R job
    // CWR   | issue one buffered coefficient write
    // RUN   | one filter tap per cycle for the latched channel
    // DONE  | pulse out_valid for the finished channel
    typedef enum logic [1:0] {IDLE, CWR, RUN, DONE} state_t;

    state_t             state;
    logic [SAMP_AW-1:0] wptr_l, wptr_r, base;
    logic               pend_l, pend_r, r_hold, cw_pend, run_ch;
    logic [15:0]        cw_buf;
    logic [COEF_AW-1:0] cwptr, caddr;
    logic [7:0]         t_cnt, taps_run, taps_eff;
    logic [FW-1:0]      f_cnt;
    logic [15:0]        cw_last;
    logic               go_cwr, go_run, clr_l, clr_r, l_ovr, r_ovr;

    assign taps_eff     = (taps_per_filter == 8'd0) ? 8'd1 : taps_per_filter;
    assign cw_last      = 16'(NUM_FILTERS) * 16'(taps_eff) - 16'd1;
    assign go_cwr       = (state == IDLE) && cw_pend && !coef_rst;
    assign go_run       = (state == IDLE) && !go_cwr && audio_en && (pend_l || pend_r);
    assign clr_l        = go_run && pend_l;
    assign clr_r        = go_run && !pend_l;
    assign l_ovr        = l_data_valid && (pend_l || (state == RUN && !run_ch));
    assign r_ovr        = r_data_valid && (pend_r || (state == RUN && run_ch));
    assign busy         = (state != IDLE);
    assign wr_addr_zero = (cwptr == '0);

    // Simultaneous L/R strobes: L goes out first, R waits one cycle in r_hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_we      <= 1'b0;
            samp_wr_ch   <= 1'b0;
            samp_wr_addr <= '0;
            wptr_l       <= '0;
            wptr_r       <= '0;
            r_hold       <= 1'b0;
        end else begin
            samp_we <= 1'b0;
            if (l_data_valid) begin
                samp_we      <= 1'b1;
                samp_wr_ch   <= 1'b0;
                samp_wr_addr <= wptr_l;
                wptr_l       <= wptr_l + 1'b1;
                r_hold       <= r_data_valid || r_hold;
            end else if (r_data_valid || r_hold) begin
                samp_we      <= 1'b1;
                samp_wr_ch   <= 1'b1;
                samp_wr_addr <= wptr_r;
                wptr_r       <= wptr_r + 1'b1;
                r_hold       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pend_l       <= 1'b0;
            pend_r       <= 1'b0;
            overrun      <= 1'b0;
            cw_pend      <= 1'b0;
            cw_buf       <= '0;
            cwptr        <= '0;
            caddr        <= '0;
            run_ch       <= 1'b0;
            base         <= '0;
            taps_run     <= 8'd1;
            t_cnt        <= '0;
            f_cnt        <= '0;
            coef_addr    <= '0;
            coef_we      <= 1'b0;
            coef_wdata   <= '0;
            samp_rd_ch   <= 1'b0;
            samp_rd_addr <= '0;
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            mac_last     <= 1'b0;
            mac_filter   <= '0;
            out_valid_l  <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            mac_en      <= 1'b0;
            mac_clr     <= 1'b0;
            mac_last    <= 1'b0;
            coef_we     <= 1'b0;
            out_valid_l <= 1'b0;
            out_valid_r <= 1'b0;

            // A fresh strobe beats the clear from a job starting in the same cycle.
            pend_l  <= audio_en && (l_data_valid || (pend_l && !clr_l));
            pend_r  <= audio_en && (r_data_valid || (pend_r && !clr_r));
            overrun <= audio_en && (overrun || l_ovr || r_ovr);

            if (coef_rst) begin
                cw_pend <= 1'b0;
                cwptr   <= '0;
            end else if (coef_wr_en) begin
                cw_pend <= 1'b1;
                cw_buf  <= coef_wr_data;
            end else if (state == CWR) begin
                cw_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (go_cwr) begin
                        state <= CWR;
                    end else if (go_run) begin
                        state    <= RUN;
                        run_ch   <= !pend_l;
                        base     <= (pend_l ? wptr_l : wptr_r) - 1'b1;
                        taps_run <= taps_eff;
                        t_cnt    <= '0;
                        f_cnt    <= '0;
                        caddr    <= '0;
                    end
                end
                CWR: begin
                    state <= IDLE;
                    if (!coef_rst) begin
                        coef_we    <= 1'b1;
                        coef_addr  <= cwptr;
                        coef_wdata <= cw_buf;
                        cwptr      <= (16'(cwptr) >= cw_last) ? '0 : cwptr + 1'b1;
                    end
                end
                RUN: begin
                    if (!audio_en) begin
                        state <= IDLE;
                    end else begin
                        mac_en       <= 1'b1;
                        mac_clr      <= (t_cnt == 8'd0);
                        mac_last     <= (t_cnt == taps_run - 8'd1);
                        mac_filter   <= f_cnt;
                        coef_addr    <= caddr;
                        samp_rd_addr <= base - SAMP_AW'(t_cnt);
                        samp_rd_ch   <= run_ch;
                        caddr        <= caddr + 1'b1;
                        if (t_cnt == taps_run - 8'd1) begin
                            t_cnt <= '0;
                            if (f_cnt == FW'(NUM_FILTERS - 1))
                                state <= DONE;
                            else
                                f_cnt <= f_cnt + 1'b1;
                        end else begin
                            t_cnt <= t_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (audio_en) begin
                        out_valid_l <= !run_ch;
                        out_valid_r <= run_ch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: sample writes, tap scheduling, coef arbitration,
// overrun and abort handling, with hand-derived expectations.
module tb_fir_tap_sequencer;

    localparam int NF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        audio_en = 1'b0;
    logic        coef_rst = 1'b0;
    logic [7:0]  taps_per_filter = 8'd4;
    logic        coef_wr_en = 1'b0;
    logic [15:0] coef_wr_data = '0;
    logic        l_data_valid = 1'b0;
    logic        r_data_valid = 1'b0;
    logic [9:0]  coef_addr;
    logic        coef_we;
    logic [15:0] coef_wdata;
    logic        samp_we, samp_wr_ch, samp_rd_ch;
    logic [7:0]  samp_wr_addr, samp_rd_addr;
    logic        mac_clr, mac_en, mac_last;
    logic [1:0]  mac_filter;
    logic        out_valid_l, out_valid_r, busy, wr_addr_zero, overrun;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] wl = 8'd0;
    logic [7:0] wr = 8'd0;

    fir_tap_sequencer dut (
        .clk(clk), .reset(reset), .audio_en(audio_en), .coef_rst(coef_rst),
        .taps_per_filter(taps_per_filter), .coef_wr_en(coef_wr_en), .coef_wr_data(coef_wr_data),
        .l_data_valid(l_data_valid), .r_data_valid(r_data_valid),
        .coef_addr(coef_addr), .coef_we(coef_we), .coef_wdata(coef_wdata),
        .samp_we(samp_we), .samp_wr_ch(samp_wr_ch), .samp_wr_addr(samp_wr_addr),
        .samp_rd_ch(samp_rd_ch), .samp_rd_addr(samp_rd_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last), .mac_filter(mac_filter),
        .out_valid_l(out_valid_l), .out_valid_r(out_valid_r), .busy(busy),
        .wr_addr_zero(wr_addr_zero), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_l();
        l_data_valid = 1'b1;
        @(negedge clk);
        l_data_valid = 1'b0;
    endtask

    // Follows one job from its first mac_en through out_valid, checking every tap.
    task automatic check_job(input logic ch, input int tt, input logic [7:0] b, output int waited);
        logic [25:0] act_v, exp_v;
        waited = 0;
        while (mac_en !== 1'b1 && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (mac_en !== 1'b1) begin
            mismatched++;
            $display("FAIL job_start ch=%0d: mac_en=%b after %0d cycles, required 1", ch, mac_en, waited);
            return;
        end
        for (int i = 0; i < NF * tt; i++) begin
            int tap;
            tap = i % tt;
            act_v = {mac_en, mac_clr, mac_last, mac_filter, coef_addr, samp_rd_addr,
                     samp_rd_ch, out_valid_l, out_valid_r};
            exp_v = {1'b1, tap == 0, tap == tt - 1, 2'(i / tt), 10'(i), 8'(b - 8'(tap)),
                     ch, 2'b00};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL job_tap ch=%0d i=%0d: got %h, required %h", ch, i, act_v, exp_v);
            end
            @(negedge clk);
        end
        compared++;
        if ({mac_en, out_valid_l, out_valid_r} !== {1'b0, ch == 1'b0, ch == 1'b1}) begin
            mismatched++;
            $display("FAIL job_done ch=%0d: mac_en/ovl/ovr=%b%b%b, required 0%b%b",
                     ch, mac_en, out_valid_l, out_valid_r, ch == 1'b0, ch == 1'b1);
        end
    endtask

    task automatic do_coef_write(input logic [15:0] d, input logic [9:0] a, input logic z);
        int n;
        coef_wr_en   = 1'b1;
        coef_wr_data = d;
        @(negedge clk);
        coef_wr_en = 1'b0;
        n = 0;
        while (coef_we !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if ({coef_we, coef_addr, coef_wdata} !== {1'b1, a, d}) begin
            mismatched++;
            $display("FAIL coef_write: we/addr/data=%b/%0d/%h, required 1/%0d/%h",
                     coef_we, coef_addr, coef_wdata, a, d);
        end
        compared++;
        if (wr_addr_zero !== z) begin
            mismatched++;
            $display("FAIL coef_wr_addr_zero: got %b, required %b", wr_addr_zero, z);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [54:0] v;
        int n;
        @(negedge clk);
        v = {coef_addr, coef_we, coef_wdata, samp_we, samp_wr_ch, samp_wr_addr, samp_rd_ch,
             samp_rd_addr, mac_clr, mac_en, mac_last, mac_filter, out_valid_l, out_valid_r,
             busy, overrun};
        compared++;
        if (v !== '0 || wr_addr_zero !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_init: outputs=%h zero=%b, required 0 and 1", v, wr_addr_zero);
        end
        reset = 1'b0;
        audio_en = 1'b1;
        taps_per_filter = 8'd8;
        @(negedge clk);
        pulse_l();
        n = 0;
        while (mac_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        compared++;
        if (mac_en !== 1'b1 || coef_addr !== 10'd3) begin
            mismatched++;
            $display("FAIL reset_pre_tap3: mac_en=%b coef_addr=%0d, required 1/3", mac_en, coef_addr);
        end
        #2 reset = 1'b1;
        #1;
        v = {coef_addr, coef_we, coef_wdata, samp_we, samp_wr_ch, samp_wr_addr, samp_rd_ch,
             samp_rd_addr, mac_clr, mac_en, mac_last, mac_filter, out_valid_l, out_valid_r,
             busy, overrun};
        compared++;
        if (v !== '0 || wr_addr_zero !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_midrun: outputs=%h zero=%b, required 0 and 1", v, wr_addr_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        wl = 8'd0;
        wr = 8'd0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || mac_en !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_after: busy=%b mac_en=%b, required 0/0", busy, mac_en);
        end
    endtask

    task automatic test_single_job();
        int n, w;
        taps_per_filter = 8'd4;
        pulse_l();
        compared++;
        if ({samp_we, samp_wr_ch, samp_wr_addr} !== {1'b1, 1'b0, wl}) begin
            mismatched++;
            $display("FAIL single_samp_write: we/ch/addr=%b/%b/%0d, required 1/0/%0d",
                     samp_we, samp_wr_ch, samp_wr_addr, wl);
        end
        wl++;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_job(1'b0, 4, wl - 8'd1, w);
        compared++;
        if (w !== 1) begin
            mismatched++;
            $display("FAIL single_latency: first tap %0d cycles after RUN entry, required 1 (17 to out_valid)", w);
        end
    endtask

    task automatic test_both_strobes();
        int w;
        l_data_valid = 1'b1;
        r_data_valid = 1'b1;
        @(negedge clk);
        l_data_valid = 1'b0;
        r_data_valid = 1'b0;
        compared++;
        if ({samp_we, samp_wr_ch, samp_wr_addr} !== {1'b1, 1'b0, wl}) begin
            mismatched++;
            $display("FAIL both_write_l: we/ch/addr=%b/%b/%0d, required 1/0/%0d",
                     samp_we, samp_wr_ch, samp_wr_addr, wl);
        end
        wl++;
        @(negedge clk);
        compared++;
        if ({samp_we, samp_wr_ch, samp_wr_addr} !== {1'b1, 1'b1, wr}) begin
            mismatched++;
            $display("FAIL both_write_r: we/ch/addr=%b/%b/%0d, required 1/1/%0d",
                     samp_we, samp_wr_ch, samp_wr_addr, wr);
        end
        wr++;
        check_job(1'b0, 4, wl - 8'd1, w);
        check_job(1'b1, 4, wr - 8'd1, w);
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL both_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_coef_writes();
        int n;
        logic seen_we;
        coef_rst = 1'b1;
        @(negedge clk);
        coef_rst = 1'b0;
        taps_per_filter = 8'd8;
        pulse_l();
        wl++;
        n = 0;
        while (mac_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        coef_wr_en = 1'b1;
        coef_wr_data = 16'hA5A5;
        @(negedge clk);
        coef_wr_data = 16'h1234;
        @(negedge clk);
        coef_wr_en = 1'b0;
        seen_we = 1'b0;
        n = 0;
        while (out_valid_l !== 1'b1 && n < 60) begin
            seen_we = seen_we | coef_we;
            @(negedge clk);
            n++;
        end
        compared++;
        if (seen_we !== 1'b0 || out_valid_l !== 1'b1) begin
            mismatched++;
            $display("FAIL coef_held_in_run: we_seen=%b out_valid_l=%b, required 0/1", seen_we, out_valid_l);
        end
        n = 0;
        while (coef_we !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if ({coef_we, coef_addr, coef_wdata} !== {1'b1, 10'd0, 16'h1234}) begin
            mismatched++;
            $display("FAIL coef_last_wins: we/addr/data=%b/%0d/%h, required 1/0/1234",
                     coef_we, coef_addr, coef_wdata);
        end
        seen_we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_we = seen_we | coef_we;
        end
        compared++;
        if (seen_we !== 1'b0) begin
            mismatched++;
            $display("FAIL coef_single_write: extra coef_we=%b, required 0", seen_we);
        end
        taps_per_filter = 8'd1;
        coef_rst = 1'b1;
        @(negedge clk);
        coef_rst = 1'b0;
        do_coef_write(16'h0101, 10'd0, 1'b0);
        do_coef_write(16'h0202, 10'd1, 1'b0);
        do_coef_write(16'h0303, 10'd2, 1'b0);
        do_coef_write(16'h0404, 10'd3, 1'b1);
        do_coef_write(16'h0505, 10'd0, 1'b0);
        do_coef_write(16'h0606, 10'd1, 1'b0);
        coef_rst = 1'b1;
        @(negedge clk);
        coef_rst = 1'b0;
        compared++;
        if (wr_addr_zero !== 1'b1) begin
            mismatched++;
            $display("FAIL coef_rst_zero: got %b, required 1", wr_addr_zero);
        end
        do_coef_write(16'h0707, 10'd0, 1'b0);
    endtask

    task automatic test_overrun();
        taps_per_filter = 8'd4;
        l_data_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        l_data_valid = 1'b0;
        compared++;
        if ({overrun, samp_we, samp_wr_addr} !== {1'b1, 1'b1, 8'(wl + 8'd1)}) begin
            mismatched++;
            $display("FAIL overrun_set: ovr/we/addr=%b/%b/%0d, required 1/1/%0d",
                     overrun, samp_we, samp_wr_addr, wl + 8'd1);
        end
        wl = wl + 8'd2;
        @(negedge clk);
        audio_en = 1'b0;
        @(negedge clk);
        compared++;
        if ({overrun, busy, mac_en, out_valid_l} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_clear: ovr/busy/mac_en/ovl=%b%b%b%b, required 0000",
                     overrun, busy, mac_en, out_valid_l);
        end
        pulse_l();
        compared++;
        if ({samp_we, samp_wr_addr} !== {1'b1, wl}) begin
            mismatched++;
            $display("FAIL abort_samp_write: we/addr=%b/%0d, required 1/%0d", samp_we, samp_wr_addr, wl);
        end
        wl++;
        audio_en = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if ({busy, overrun, mac_en} !== 3'b000) begin
            mismatched++;
            $display("FAIL abort_pend_cleared: busy/ovr/mac_en=%b%b%b, required 000", busy, overrun, mac_en);
        end
    endtask

    task automatic test_taps_zero_and_wrap();
        int w;
        taps_per_filter = 8'd0;
        pulse_l();
        wl++;
        check_job(1'b0, 1, wl - 8'd1, w);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wl = 8'd0;
        wr = 8'd0;
        taps_per_filter = 8'd2;
        pulse_l();
        wl++;
        check_job(1'b0, 2, 8'd0, w);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_both_strobes();
        test_coef_writes();
        test_overrun();
        test_taps_zero_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
